// File: rtl/wb_multibot_ctrl.sv
// ---------------------------------------------------------------------------
// wb_multibot_ctrl
//
// Wishbone slave register block for up to four robot channels. Each channel
// captures a coherent snapshot of its status word on a rising edge of its
// update strobe, flags the update as pending, and holds one motor-control
// byte that software can write. A global interrupt enable masks the pending
// bits into a single registered interrupt line.
//
// Register map (A = wb_adr_i[ADDR_W-1:0]):
//   A < 0x80 : channel k = A[6:5], offset = A[4:0]
//       0x0C BOT_INFO  RO  snapshot of bot_info_i channel k
//       0x10 BOT_CTRL  RW  byte 0 drives bot_ctrl_o channel k
//       0x14 UPD_SYNC  RO  bit0 = pending[k]
//       0x18 INT_ACK   W1C bit0 clears pending[k], reads 0
//       0x1C MISSED    RO  missed-update counter, any write clears
//                          (only with WB_MULTIBOT_MISSED_CNT_EN)
//   0x80 IRQ_PEND RO bits [N_BOTS-1:0]
//   0x84 IRQ_EN   RW bits [N_BOTS-1:0]
//   Anything else, or a channel k >= N_BOTS, answers with wb_err_o.
//
// Optional feature macro: WB_MULTIBOT_MISSED_CNT_EN
//
// Parameters:
//   N_BOTS  number of bot channels, 1..4
//   ADDR_W  number of low address bits decoded, 8..31
//
// Ports:
//   clk            system clock, rising edge
//   rstn           asynchronous active-low reset
//   wb_adr_i ...   Wishbone slave request (adr, dat, sel, we, cyc, stb)
//   wb_dat_o ...   Wishbone slave response (dat, ack, err)
//   bot_info_i     32 bits per channel: {LocX, LocY, Sensors, BotInfo}
//   upd_sysregs_i  per-channel update strobe, synchronous to clk
//   bot_ctrl_o     8 bits per channel motor control
//   irq_o          registered OR of enabled pending bits
// ---------------------------------------------------------------------------
module wb_multibot_ctrl #(
    parameter int N_BOTS = 2,
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [31:0]           wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    input  logic [32*N_BOTS-1:0]  bot_info_i,
    input  logic [N_BOTS-1:0]     upd_sysregs_i,
    output logic [8*N_BOTS-1:0]   bot_ctrl_o,
    output logic                  irq_o
);

    localparam logic [4:0] OFF_INFO = 5'h0C;
    localparam logic [4:0] OFF_CTRL = 5'h10;
    localparam logic [4:0] OFF_SYNC = 5'h14;
    localparam logic [4:0] OFF_ACK  = 5'h18;
`ifdef WB_MULTIBOT_MISSED_CNT_EN
    localparam logic [4:0] OFF_MISS = 5'h1C;
`endif

    logic [31:0]       snapshot [N_BOTS];
    logic [7:0]        ctrl     [N_BOTS];
    logic [N_BOTS-1:0] pending;
    logic [N_BOTS-1:0] irq_en;
    logic [N_BOTS-1:0] upd_prev;
    logic              armed;
`ifdef WB_MULTIBOT_MISSED_CNT_EN
    logic [7:0]        missed   [N_BOTS];
`endif

    logic [ADDR_W-1:0] addr;
    logic [1:0]        ch;
    logic [4:0]        off;
    logic              is_chan;
    logic              glob_pend;
    logic              glob_en;
    logic [N_BOTS-1:0] chan_sel;
    logic              hit;
    logic [31:0]       rd_data;
    logic              req;
    logic              wr;
    logic [N_BOTS-1:0] edge_det;

    assign addr      = wb_adr_i[ADDR_W-1:0];
    assign ch        = addr[6:5];
    assign off       = addr[4:0];
    assign is_chan   = (addr[ADDR_W-1:7] == '0);
    assign glob_pend = (addr == ADDR_W'(8'h80));
    assign glob_en   = (addr == ADDR_W'(8'h84));

    // A new access is accepted only while no response is on the bus, so a
    // master holding cyc/stb high can never see two back-to-back acks.
    assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign wr  = req & hit & wb_we_i & wb_sel_i[0];

    // The first cycle after reset release only primes upd_prev, so a strobe
    // already high when reset lifts is not mistaken for a fresh edge.
    assign edge_det = upd_sysregs_i & ~upd_prev & {N_BOTS{armed}};

    // Address decode and read mux; 'hit' doubles as the ack/err selector.
    always_comb begin
        chan_sel = '0;
        hit      = 1'b0;
        rd_data  = '0;
        for (int i = 0; i < N_BOTS; i++) begin
            if (is_chan && (32'(ch) == i)) begin
                chan_sel[i] = 1'b1;
                case (off)
                    OFF_INFO: begin
                        hit     = 1'b1;
                        rd_data = snapshot[i];
                    end
                    OFF_CTRL: begin
                        hit     = 1'b1;
                        rd_data = {24'h0, ctrl[i]};
                    end
                    OFF_SYNC: begin
                        hit     = 1'b1;
                        rd_data = {31'h0, pending[i]};
                    end
                    OFF_ACK: begin
                        hit     = 1'b1;
                    end
`ifdef WB_MULTIBOT_MISSED_CNT_EN
                    OFF_MISS: begin
                        hit     = 1'b1;
                        rd_data = {24'h0, missed[i]};
                    end
`endif
                    default: ;
                endcase
            end
        end
        if (glob_pend) begin
            hit     = 1'b1;
            rd_data = 32'(pending);
        end
        if (glob_en) begin
            hit     = 1'b1;
            rd_data = 32'(irq_en);
        end
    end

    // Bus response, register state, update-edge capture and interrupt.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
            pending  <= '0;
            irq_en   <= '0;
            irq_o    <= 1'b0;
            upd_prev <= '0;
            armed    <= 1'b0;
            for (int i = 0; i < N_BOTS; i++) begin
                snapshot[i] <= '0;
                ctrl[i]     <= '0;
`ifdef WB_MULTIBOT_MISSED_CNT_EN
                missed[i]   <= '0;
`endif
            end
        end else begin
            wb_ack_o <= req & hit;
            wb_err_o <= req & ~hit;
            wb_dat_o <= (req & hit & ~wb_we_i) ? rd_data : '0;
            armed    <= 1'b1;
            upd_prev <= upd_sysregs_i;
            irq_o    <= |(pending & irq_en);

            if (wr && glob_en) begin
                irq_en <= wb_dat_i[N_BOTS-1:0];
            end

            for (int i = 0; i < N_BOTS; i++) begin
                if (edge_det[i]) begin
                    snapshot[i] <= bot_info_i[32*i +: 32];
                end
                if (wr && chan_sel[i] && (off == OFF_CTRL)) begin
                    ctrl[i] <= wb_dat_i[7:0];
                end
                // A fresh update wins over a simultaneous acknowledge.
                if (edge_det[i]) begin
                    pending[i] <= 1'b1;
                end else if (wr && chan_sel[i] && (off == OFF_ACK) && wb_dat_i[0]) begin
                    pending[i] <= 1'b0;
                end
`ifdef WB_MULTIBOT_MISSED_CNT_EN
                // An update landing on a still-pending channel overwrote data
                // software never acknowledged; count it, saturating.
                if (wr && chan_sel[i] && (off == OFF_MISS)) begin
                    missed[i] <= '0;
                end else if (edge_det[i] && pending[i] && (missed[i] != 8'hFF)) begin
                    missed[i] <= missed[i] + 8'd1;
                end
`endif
            end
        end
    end

    for (genvar g = 0; g < N_BOTS; g++) begin : g_ctrl_out
        assign bot_ctrl_o[8*g +: 8] = ctrl[g];
    end

    logic unused_bits;
    assign unused_bits = ^{wb_adr_i[31:ADDR_W], wb_dat_i[31:8], wb_sel_i[3:1]};

endmodule

// File: tb/tb_wb_multibot_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wb_multibot_ctrl
//
// Directed self-checking bench for wb_multibot_ctrl with N_BOTS=2,
// ADDR_W=8. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_wb_multibot_ctrl;

    localparam int N_BOTS = 2;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [31:0]          wb_adr_i;
    logic [31:0]          wb_dat_i;
    logic [3:0]           wb_sel_i;
    logic                 wb_we_i;
    logic                 wb_cyc_i;
    logic                 wb_stb_i;
    logic [31:0]          wb_dat_o;
    logic                 wb_ack_o;
    logic                 wb_err_o;
    logic [32*N_BOTS-1:0] bot_info_i;
    logic [N_BOTS-1:0]    upd_sysregs_i;
    logic [8*N_BOTS-1:0]  bot_ctrl_o;
    logic                 irq_o;

    int total = 0;
    int bad   = 0;

    wb_multibot_ctrl #(.N_BOTS(N_BOTS), .ADDR_W(8)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .wb_adr_i      (wb_adr_i),
        .wb_dat_i      (wb_dat_i),
        .wb_sel_i      (wb_sel_i),
        .wb_we_i       (wb_we_i),
        .wb_cyc_i      (wb_cyc_i),
        .wb_stb_i      (wb_stb_i),
        .wb_dat_o      (wb_dat_o),
        .wb_ack_o      (wb_ack_o),
        .wb_err_o      (wb_err_o),
        .bot_info_i    (bot_info_i),
        .upd_sysregs_i (upd_sysregs_i),
        .bot_ctrl_o    (bot_ctrl_o),
        .irq_o         (irq_o)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // One complete Wishbone access with a bounded wait for ack or err.
    task automatic applyStimulus(input logic [31:0] addr, input logic we,
                                 input logic [31:0] data, input logic [3:0] sel,
                                 output logic [31:0] rdata, output logic acked,
                                 output logic erred);
        @(posedge clk);
        #1;
        wb_adr_i = addr;
        wb_dat_i = data;
        wb_sel_i = sel;
        wb_we_i  = we;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        acked = 1'b0;
        erred = 1'b0;
        rdata = '0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            if (wb_ack_o || wb_err_o) begin
                acked = wb_ack_o;
                erred = wb_err_o;
                rdata = wb_dat_o;
                break;
            end
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        if (!acked && !erred) checkOutput("bus timeout", 32'd0, 32'd1);
    endtask

    task automatic readCheck(input string tag, input logic [31:0] addr,
                             input logic [31:0] expected);
        logic [31:0] d;
        logic a, e;
        applyStimulus(addr, 1'b0, 32'h0, 4'hF, d, a, e);
        checkOutput({tag, " ack"}, 32'(a), 32'd1);
        checkOutput({tag, " data"}, d, expected);
    endtask

    task automatic writeCheck(input string tag, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] sel);
        logic [31:0] d;
        logic a, e;
        applyStimulus(addr, 1'b1, data, sel, d, a, e);
        checkOutput({tag, " ack"}, 32'(a), 32'd1);
    endtask

    task automatic errCheck(input string tag, input logic [31:0] addr, input logic we);
        logic [31:0] d;
        logic a, e;
        applyStimulus(addr, we, 32'h1, 4'hF, d, a, e);
        checkOutput({tag, " err"}, 32'(e), 32'd1);
        checkOutput({tag, " no ack"}, 32'(a), 32'd0);
        checkOutput({tag, " data zero"}, d, 32'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, " err single pulse"}, 32'(wb_err_o), 32'd0);
    endtask

    // One-cycle high pulse on a channel update strobe; the edge is taken
    // at the posedge just before this task returns.
    task automatic pulseUpd(input int chn);
        @(posedge clk);
        #1;
        upd_sysregs_i[chn] = 1'b1;
        @(posedge clk);
        #1;
        upd_sysregs_i[chn] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstn          = 1'b0;
        wb_adr_i      = '0;
        wb_dat_i      = '0;
        wb_sel_i      = '0;
        wb_we_i       = 1'b0;
        wb_cyc_i      = 1'b0;
        wb_stb_i      = 1'b0;
        bot_info_i    = {32'hCAFE0001, 32'h11223344};
        upd_sysregs_i = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset ack", 32'(wb_ack_o), 32'd0);
        checkOutput("reset err", 32'(wb_err_o), 32'd0);
        checkOutput("reset dat", wb_dat_o, 32'd0);
        checkOutput("reset bot_ctrl", 32'(bot_ctrl_o), 32'd0);
        checkOutput("reset irq", 32'(irq_o), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        // Control byte write on channel 1 only.
        writeCheck("ctrl ch1 write", 32'h30, 32'h0000005A, 4'hF);
        checkOutput("ctrl ch1 output", 32'(bot_ctrl_o), 32'h00005A00);
        writeCheck("ctrl ch0 sel0 low", 32'h10, 32'h000001A5, 4'hE);
        checkOutput("ctrl ch0 ignored", 32'(bot_ctrl_o), 32'h00005A00);
        readCheck("ctrl ch1 read", 32'h30, 32'h5A);

        // Snapshot stays coherent after the live input moves on.
        pulseUpd(0);
        bot_info_i[31:0] = 32'hDEADBEEF;
        readCheck("info ch0 snapshot", 32'h0C, 32'h11223344);
        readCheck("sync ch0 pending", 32'h14, 32'h1);
        readCheck("irq pend", 32'h80, 32'h1);
        checkOutput("irq masked", 32'(irq_o), 32'd0);

        // Interrupt path: acknowledge, enable, new update, acknowledge.
        writeCheck("ack ch0", 32'h18, 32'h1, 4'hF);
        readCheck("sync ch0 cleared", 32'h14, 32'h0);
        writeCheck("irq_en write", 32'h84, 32'h1, 4'hF);
        readCheck("irq_en read", 32'h84, 32'h1);
        checkOutput("irq idle", 32'(irq_o), 32'd0);
        pulseUpd(0);
        @(posedge clk);
        #1;
        checkOutput("irq raised", 32'(irq_o), 32'd1);
        writeCheck("ack ch0 irq", 32'h18, 32'h1, 4'hF);
        checkOutput("irq still high in ack cycle", 32'(irq_o), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("irq dropped", 32'(irq_o), 32'd0);
        readCheck("pend after ack", 32'h80, 32'h0);
        readCheck("int_ack reads zero", 32'h18, 32'h0);

        // Update edge and acknowledge in the same cycle: set wins.
        @(posedge clk);
        #1;
        wb_adr_i = 32'h18;
        wb_dat_i = 32'h1;
        wb_sel_i = 4'hF;
        wb_we_i  = 1'b1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        upd_sysregs_i[0] = 1'b1;
        @(posedge clk);
        #1;
        upd_sysregs_i[0] = 1'b0;
        checkOutput("collide ack", 32'(wb_ack_o), 32'd1);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        readCheck("collide pending kept", 32'h14, 32'h1);

        // Master holding the strobe must never see back-to-back acks.
        @(posedge clk);
        #1;
        wb_adr_i = 32'h30;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("held first ack", 32'(wb_ack_o), 32'd1);
        checkOutput("held first data", wb_dat_o, 32'h5A);
        @(posedge clk);
        #1;
        checkOutput("held gap no ack", 32'(wb_ack_o), 32'd0);
        checkOutput("held gap data zero", wb_dat_o, 32'd0);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        @(posedge clk);
        #1;

        // Unmapped addresses and missing channels.
        errCheck("err ch2", 32'h40, 1'b0);
        errCheck("err off 0x08", 32'h08, 1'b0);
        errCheck("err glob 0x88", 32'h88, 1'b0);
        errCheck("err write ch3 ctrl", 32'h70, 1'b1);
        checkOutput("err write no effect", 32'(bot_ctrl_o), 32'h00005A00);

`ifdef WB_MULTIBOT_MISSED_CNT_EN
        readCheck("missed ch1 start", 32'h3C, 32'h0);
        for (int n = 0; n < 300; n++) pulseUpd(1);
        readCheck("missed ch1 saturated", 32'h3C, 32'hFF);
        writeCheck("missed ch1 clear", 32'h3C, 32'h0, 4'hF);
        readCheck("missed ch1 cleared", 32'h3C, 32'h0);
`else
        errCheck("err missed read", 32'h1C, 1'b0);
        errCheck("err missed write", 32'h3C, 1'b1);
`endif

        // Reset arriving mid-access: access dropped, no ack afterwards.
        @(posedge clk);
        #1;
        wb_adr_i = 32'h30;
        wb_dat_i = 32'h77;
        wb_sel_i = 4'hF;
        wb_we_i  = 1'b1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        #2;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midreset ack", 32'(wb_ack_o), 32'd0);
        checkOutput("midreset bot_ctrl", 32'(bot_ctrl_o), 32'd0);
        checkOutput("midreset irq", 32'(irq_o), 32'd0);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        upd_sysregs_i[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("post reset no stray ack", 32'(wb_ack_o), 32'd0);
        readCheck("held strobe no edge", 32'h14, 32'h0);
        readCheck("post reset pend", 32'h80, 32'h0);
        readCheck("post reset irq_en", 32'h84, 32'h0);
        readCheck("post reset ctrl ch1", 32'h30, 32'h0);
        readCheck("post reset snapshot", 32'h0C, 32'h0);
        upd_sysregs_i[0] = 1'b0;
        pulseUpd(0);
        readCheck("edge after reset", 32'h14, 32'h1);
        readCheck("snapshot after reset", 32'h0C, 32'hDEADBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_multibot_ctrl.md
WB_MULTIBOT_CTRL -- requirements
Module: wb_multibot_ctrl

Interface
REQ-001 SHALL provide parameter N_BOTS, default 2, number of bot channels (legal range 1..4).
REQ-002 SHALL provide parameter ADDR_W, default 8, number of low wb_adr_i bits decoded.
REQ-003 SHALL provide port clk, input, 1, the single system clock; all logic in this block SHALL be clocked on its rising edge.
REQ-004 SHALL provide port rstn, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL provide ports wb_adr_i 32, wb_dat_i 32, wb_sel_i 4, wb_we_i 1, wb_cyc_i 1 and wb_stb_i 1, all inputs, forming the Wishbone slave request.
REQ-006 SHALL provide ports wb_dat_o 32, wb_ack_o 1 and wb_err_o 1, all outputs, forming the Wishbone slave response.
REQ-007 SHALL provide port bot_info_i, input, 32*N_BOTS; channel k = bits [32k+31:32k] = {LocX, LocY, Sensors, BotInfo}.
REQ-008 SHALL provide port upd_sysregs_i, input, N_BOTS, per-channel update strobe, already synchronous to clk.
REQ-009 SHALL provide port bot_ctrl_o, output, 8*N_BOTS, per-channel motor control byte.
REQ-010 SHALL provide port irq_o, output, 1, registered OR of enabled pending updates.

Function
REQ-011 SHALL decode address A = wb_adr_i[ADDR_W-1:0], channel k = A[6:5], offset = A[4:0], for A < 0x80.
REQ-012 SHALL implement, per channel: 0x0C BOT_INFO (RO, snapshot), 0x10 BOT_CTRL (RW, byte 0), 0x14 UPD_SYNC (RO, bit0 = pending[k]), 0x18 INT_ACK (W1C, bit0 clears pending[k]; reads 0).
REQ-013 SHALL implement global registers 0x80 IRQ_PEND (RO, bits [N_BOTS-1:0]) and 0x84 IRQ_EN (RW, bits [N_BOTS-1:0]).
REQ-014 SHALL assert wb_ack_o for exactly one cycle, one cycle after wb_cyc_i & wb_stb_i is sampled with wb_ack_o low; wb_ack_o SHALL never be high on two consecutive cycles.
REQ-015 SHALL assert wb_err_o instead of wb_ack_o, with the same timing, for unmapped offsets or k >= N_BOTS; an errored access SHALL change no state.
REQ-016 SHALL present wb_dat_o registered, valid in the wb_ack_o cycle, and 0 when not acking.
REQ-017 SHALL perform a write only in the request cycle, with wb_we_i=1 and wb_sel_i[0]=1; writes with wb_sel_i[0]=0 SHALL be acked and ignored.
REQ-018 SHALL detect a rising edge of upd_sysregs_i[k] (registered previous value), set pending[k] and capture bot_info_i[k] into snapshot[k] in the same cycle.
REQ-019 SHALL hold snapshot[k] constant between update edges so that a read returns coherent data.
REQ-020 SHALL give set priority when an update edge and an INT_ACK clear of channel k occur in the same cycle: pending[k] SHALL end at 1.
REQ-021 SHALL compute irq_o = |(pending & IRQ_EN), registered, one cycle after pending changes.

Reset
REQ-022 SHALL, while rstn=0, clear wb_ack_o, wb_err_o, wb_dat_o, bot_ctrl_o, pending, snapshots, IRQ_EN, irq_o and the edge registers asynchronously.
REQ-023 SHALL drop any in-flight access, with no ack issued, when reset asserts mid-access; after release the block SHALL answer only new requests.
REQ-024 SHALL not count upd_sysregs_i held high across reset release as an edge.

Configuration
REQ-025 SHALL support macro WB_MULTIBOT_MISSED_CNT_EN; when defined, an 8-bit per-channel counter SHALL increment on an update edge that arrives while pending[k]=1, SHALL saturate at 0xFF, SHALL read at offset 0x1C and SHALL clear on any write to 0x1C.
REQ-026 SHALL, when WB_MULTIBOT_MISSED_CNT_EN is undefined, contain no counter logic and SHALL return wb_err_o for offset 0x1C.

Verification
REQ-027 SHALL cover: write 0x10 data 0x5A sel=0xF on ch1 -> bot_ctrl_o[15:8]=0x5A after ack, other channels unchanged.
REQ-028 SHALL cover: upd edge ch0 with info 0x11223344, then info changes -> read 0x0C returns 0x11223344 and 0x14 returns 1.
REQ-029 SHALL cover: IRQ_EN=0x1 with update on ch0 -> irq_o=1 within 2 cycles; write 1 to 0x18 -> pending=0 and irq_o=0 one cycle later.
REQ-030 SHALL cover: update edge and INT_ACK on the same cycle -> pending stays 1.
REQ-031 SHALL cover: read 0x40 with N_BOTS=2, and read 0x08 -> wb_err_o single pulse, wb_ack_o=0.
REQ-032 SHALL cover, with the macro defined: 300 edges with no ack -> counter reads 0xFF.
